pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter: PC_INIT, default 32'h00000000, PC value loaded into the program counter after reset.
REQ-002 SHALL have port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: ihit  input  1  instruction memory completed the fetch at pc_out this cycle.
REQ-005 SHALL have port: stall  input  1  datapath hazard stall; PC SHALL NOT advance while high.
REQ-006 SHALL have port: pc_out  input  32  current PC from the program counter.
REQ-007 SHALL have port: jump  input  1  jump/jr resolved this cycle.
REQ-008 SHALL have port: jump_target  input  32  jump destination.
REQ-009 SHALL have port: branch_taken  input  1  taken branch resolved this cycle.
REQ-010 SHALL have port: branch_target  input  32  branch destination.
REQ-011 SHALL have port: halt  input  1  halt instruction decoded this cycle.
REQ-012 SHALL have port: pc_next  output  32  next PC value to the program counter.
REQ-013 SHALL have port: pcWEN  output  1  program counter write enable.
REQ-014 SHALL have port: iREN  output  1  instruction read enable.
REQ-015 SHALL have port: halted  output  1  sticky halt status.
REQ-016 SHALL have port: fetch_count  output  32  number of PC advances since reset.

Function
REQ-017 SHALL implement three states: INIT, FETCH, HALTED.
REQ-018 INIT: pcWEN=1, pc_next=PC_INIT, iREN=0; unconditional transition to FETCH next cycle; fetch_count not incremented.
REQ-019 FETCH: iREN=1; advance condition adv = ihit & ~stall & ~halt; pcWEN=adv (combinational, same cycle).
REQ-020 FETCH, halt=1: pcWEN=0, pending redirect discarded, transition to HALTED; halt has priority over all redirects and ihit.
REQ-021 HALTED: pcWEN=0, iREN=0, halted=1; remains until RST; all other inputs ignored.
REQ-022 Redirect priority in a cycle: jump > branch_taken > sequential.
REQ-023 pc_next in FETCH: jump_target if jump; else branch_target if branch_taken; else pending target if pending valid; else pc_out+4.
REQ-024 pc_out+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-025 Redirect targets SHALL have bits [1:0] forced to 2'b00 before use or storage.
REQ-026 Redirect (jump or branch_taken) in a FETCH cycle with adv=0 and halt=0 SHALL be stored in a one-entry pending register (valid + 32-bit target); a later redirect overwrites it (latest wins).
REQ-027 Pending entry SHALL be cleared in the cycle adv=1 (whether pending or a same-cycle redirect was used).
REQ-028 fetch_count SHALL increment by 1 on every FETCH cycle with pcWEN=1, saturating at 32'hFFFFFFFF.
REQ-029 pc_next SHALL equal pc_out+4 when pcWEN=0 in FETCH with no redirect/pending, and pc_out in HALTED (value don't-care for PC, defined for checking).

Reset
REQ-030 RST=1 at a rising edge SHALL set state=INIT, pending valid=0, pending target=0, fetch_count=0, halted=0, regardless of current state, including mid-stall or HALTED.
REQ-031 While RST=1, outputs SHALL reflect INIT: pcWEN=1, pc_next=PC_INIT, iREN=0, halted=0.

Verification
REQ-032 Reset release, PC_INIT=32'h100, ihit=1 every cycle -> cycle0 pc_next=0x100 pcWEN=1; then pc_out 0x100,0x104,0x108 with fetch_count 1,2,3.
REQ-033 pc_out=0x200, ihit=0, branch_taken=1 target=0x403 one cycle, then ihit=1 -> pcWEN=0 first cycle; next cycle pc_next=0x400 pcWEN=1; pending cleared.
REQ-034 Same cycle jump=1 target 0x800 and branch_taken=1 target 0x900, ihit=1 -> pc_next=0x800; pending stored 0x300 overridden by same-cycle redirect on advance.
REQ-035 pc_out=0xFFFFFFFC, ihit=1 -> pc_next=0x00000000, pcWEN=1.
REQ-036 halt=1 with ihit=1 and jump=1 -> pcWEN=0, next cycle halted=1 iREN=0, fetch_count frozen; RST pulse -> INIT, halted=0.
REQ-037 stall=1 with ihit=1 for 3 cycles -> pcWEN=0, fetch_count unchanged; stall drop -> advance resumes.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: picks the next PC (jump > branch > pending > +4),
// buffers one redirect across non-advancing cycles, counts advances, and halts.
module pc_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        stall,
  input  logic [31:0] pc_out,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] pc_next,
  output logic        pcWEN,
  output logic        iREN,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_t_q, pend_t_d;
  logic [31:0] cnt_q, cnt_d;

  logic        adv;
  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] seq_pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_INIT;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    adv       = ihit & ~stall & ~halt;
    redir     = jump | branch_taken;
    redir_tgt = jump ? (jump_target & ~32'd3) : (branch_target & ~32'd3);
    seq_pc    = pc_out + 32'd4;

    state_d  = state_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;
    cnt_d    = cnt_q;
    pc_next  = pc_out;
    pcWEN    = 1'b0;
    iREN     = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_INIT: begin
        pcWEN   = 1'b1;
        pc_next = PC_INIT;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        iREN    = 1'b1;
        pc_next = redir ? redir_tgt : (pend_v_q ? pend_t_q : seq_pc);
        if (halt) begin
          state_d  = S_HALTED;
          pend_v_d = 1'b0;
        end else if (adv) begin
          pcWEN    = 1'b1;
          pend_v_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        end else if (redir) begin
          pend_v_d = 1'b1;
          pend_t_d = redir_tgt;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // Reset is synchronous for state, but outputs show INIT immediately while RST is held.
    if (RST) begin
      pcWEN   = 1'b1;
      pc_next = PC_INIT;
      iREN    = 1'b0;
      halted  = 1'b0;
    end
  end

  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; pc_out is driven directly by the vectors.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, stall, jump, branch_taken, halt;
  logic [31:0] pc_out, jump_target, branch_target;
  logic [31:0] pc_next, fetch_count;
  logic        pcWEN, iREN, halted;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.PC_INIT(32'h00000100)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ihit          (ihit),
    .stall         (stall),
    .pc_out        (pc_out),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .pc_next       (pc_next),
    .pcWEN         (pcWEN),
    .iREN          (iREN),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs (called just after a falling edge) and let them settle.
  task automatic drive(input logic rst, input logic ih, input logic st,
                       input logic jp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt,
                       input logic hl, input logic [31:0] pc);
    RST = rst; ihit = ih; stall = st; jump = jp; jump_target = jt;
    branch_taken = br; branch_target = bt; halt = hl; pc_out = pc;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] npc, input logic wen,
                            input logic ren, input logic hlt, input logic [31:0] cnt);
    check({tag, ".pc_next"}, pc_next, npc);
    check({tag, ".pcWEN"}, {31'd0, pcWEN}, {31'd0, wen});
    check({tag, ".iREN"}, {31'd0, iREN}, {31'd0, ren});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
    check({tag, ".count"}, fetch_count, cnt);
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    tick();
    // reset held: INIT-looking outputs
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h0);
    expect_out("rst", 32'h100, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    // INIT cycle after release
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h0);
    expect_out("init", 32'h100, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    // sequential fetches
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h100);
    expect_out("seq0", 32'h104, 1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h104);
    expect_out("seq1", 32'h108, 1'b1, 1'b1, 1'b0, 32'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h108);
    expect_out("seq2", 32'h10C, 1'b1, 1'b1, 1'b0, 32'd2);
    tick();
    // branch without ihit -> pending 0x400 (low bits masked)
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h403, 1'b0, 32'h200);
    expect_out("br_miss", 32'h400, 1'b0, 1'b1, 1'b0, 32'd3);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h200);
    expect_out("br_pend", 32'h400, 1'b1, 1'b1, 1'b0, 32'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h400);
    expect_out("pend_clr", 32'h404, 1'b0, 1'b1, 1'b0, 32'd4);
    tick();
    // latest pending wins
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, '0, 1'b0, 32'h400);
    expect_out("jp_miss", 32'h300, 1'b0, 1'b1, 1'b0, 32'd4);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h503, 1'b0, 32'h400);
    expect_out("br_over", 32'h500, 1'b0, 1'b1, 1'b0, 32'd4);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h400);
    expect_out("latest", 32'h500, 1'b1, 1'b1, 1'b0, 32'd4);
    tick();
    // pending overridden by same-cycle redirect; jump beats branch
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, '0, 1'b0, 32'h500);
    expect_out("jp_pend", 32'h300, 1'b0, 1'b1, 1'b0, 32'd5);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h800, 1'b1, 32'h900, 1'b0, 32'h500);
    expect_out("prio", 32'h800, 1'b1, 1'b1, 1'b0, 32'd5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h800);
    expect_out("prio_clr", 32'h804, 1'b0, 1'b1, 1'b0, 32'd6);
    tick();
    // wrap
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'hFFFFFFFC);
    expect_out("wrap", 32'h0, 1'b1, 1'b1, 1'b0, 32'd6);
    tick();
    // stall three cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 32'h0);
      expect_out("stall", 32'h4, 1'b0, 1'b1, 1'b0, 32'd7);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h0);
    expect_out("unstall", 32'h4, 1'b1, 1'b1, 1'b0, 32'd7);
    tick();
    // pending before halt, then halt beats jump+ihit
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hA00, 1'b0, '0, 1'b0, 32'h4);
    expect_out("pre_halt", 32'hA00, 1'b0, 1'b1, 1'b0, 32'd8);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h900, 1'b0, '0, 1'b1, 32'h4);
    check("halt.pcWEN", {31'd0, pcWEN}, 32'd0);
    check("halt.halted", {31'd0, halted}, 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h900, 1'b1, 32'h700, 1'b0, 32'h123);
    expect_out("halted0", 32'h123, 1'b0, 1'b0, 1'b1, 32'd8);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h124);
    expect_out("halted1", 32'h124, 1'b0, 1'b0, 1'b1, 32'd8);
    tick();
    // reset from HALTED
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h124);
    expect_out("rst_h", 32'h100, 1'b1, 1'b0, 1'b0, 32'd8);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h124);
    expect_out("init2", 32'h100, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    // pending was discarded: sequential fetch follows
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h100);
    expect_out("post_rst", 32'h104, 1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    check("post_rst.count", fetch_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
